// File: rtl/rom_pwm_sequencer_if.sv
// rom_pwm_sequencer_if: PWM pattern ROM port (enable/address out, three pattern words back)
interface rom_pwm_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] out1, out2, out3;
  modport master(output en, addr, input out1, out2, out3);
  modport slave(input en, addr, output out1, out2, out3);
endinterface

// File: rtl/rom_pwm_sequencer.sv
// rom_pwm_sequencer: walks the PWM pattern ROM at a programmable step/rate and captures its words
module rom_pwm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TABLE_LEN = 65536,
  parameter int ROM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic abort,
  input  logic [ADDR_W-1:0] step,
  input  logic [15:0] tick_div,
  rom_pwm_sequencer_if.master rom,
  output logic [DATA_W-1:0] pwm1,
  output logic [DATA_W-1:0] pwm2,
  output logic [DATA_W-1:0] pwm3,
  output logic busy,
  output logic wrap_pulse
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int CW = $clog2(ROM_LAT) + 1;
  localparam logic [ADDR_W:0] TLEN = (ADDR_W+1)'(TABLE_LEN);
  state_t state, state_n;
  logic en, en_n, wrap_n, stop_pend, stop_pend_n;
  logic [ADDR_W-1:0] addr, addr_n, step_sh, step_sh_n;
  logic [15:0] div_cnt, div_cnt_n, div_sh, div_sh_n;
  logic [ROM_LAT-1:0] tok, tok_n;
  logic [CW-1:0] fin_cnt, fin_cnt_n;
  logic [DATA_W-1:0] p1_n, p2_n, p3_n;
  logic [ADDR_W:0] sum, diff;
  logic push, tick, wrap, cap;
  assign rom.en = en;
  assign rom.addr = addr;
  assign busy = state != IDLE;
  // A token marks each issued address; it reaches the top of the line when that address's data is valid
  always_comb begin
    sum = {1'b0, addr} + {1'b0, step_sh};
    diff = sum - TLEN;
    tick = div_cnt == div_sh;
    wrap = sum >= TLEN;
    cap = tok[ROM_LAT-1];
    state_n = state;
    en_n = en;
    addr_n = addr;
    step_sh_n = step_sh;
    div_sh_n = div_sh;
    div_cnt_n = div_cnt;
    stop_pend_n = stop_pend;
    fin_cnt_n = fin_cnt;
    wrap_n = 1'b0;
    push = 1'b0;
    p1_n = cap ? rom.out1 : pwm1;
    p2_n = cap ? rom.out2 : pwm2;
    p3_n = cap ? rom.out3 : pwm3;
    if (abort) begin
      state_n = IDLE;
      en_n = 1'b0;
      addr_n = '0;
      div_cnt_n = '0;
      stop_pend_n = 1'b0;
      p1_n = '0;
      p2_n = '0;
      p3_n = '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_n = RUN;
          en_n = 1'b1;
          addr_n = '0;
          div_cnt_n = '0;
          step_sh_n = step == '0 ? ADDR_W'(1) : step;
          div_sh_n = tick_div;
          stop_pend_n = stop;
          push = 1'b1;
        end
        RUN: begin
          stop_pend_n = stop_pend | stop;
          div_cnt_n = tick ? '0 : div_cnt + 16'd1;
          if (tick && wrap) begin
            wrap_n = 1'b1;
            step_sh_n = step == '0 ? ADDR_W'(1) : step;
            div_sh_n = tick_div;
            state_n = stop_pend ? FINISH : RUN;
            fin_cnt_n = '0;
            addr_n = stop_pend ? addr : diff[ADDR_W-1:0];
            push = !stop_pend;
          end else if (tick) begin
            addr_n = sum[ADDR_W-1:0];
            push = 1'b1;
          end
        end
        FINISH: if (fin_cnt == CW'(ROM_LAT-1)) begin
          state_n = IDLE;
          en_n = 1'b0;
          addr_n = '0;
          stop_pend_n = 1'b0;
          p1_n = '0;
          p2_n = '0;
          p3_n = '0;
        end else begin
          fin_cnt_n = fin_cnt + CW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
    tok_n = abort ? '0 : (tok << 1) | ROM_LAT'(push);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      en <= 1'b0;
      addr <= '0;
      step_sh <= '0;
      div_sh <= '0;
      div_cnt <= '0;
      stop_pend <= 1'b0;
      fin_cnt <= '0;
      tok <= '0;
      wrap_pulse <= 1'b0;
      pwm1 <= '0;
      pwm2 <= '0;
      pwm3 <= '0;
    end else begin
      state <= state_n;
      en <= en_n;
      addr <= addr_n;
      step_sh <= step_sh_n;
      div_sh <= div_sh_n;
      div_cnt <= div_cnt_n;
      stop_pend <= stop_pend_n;
      fin_cnt <= fin_cnt_n;
      tok <= tok_n;
      wrap_pulse <= wrap_n;
      pwm1 <= p1_n;
      pwm2 <= p2_n;
      pwm3 <= p3_n;
    end
endmodule

// File: tb/tb_rom_pwm_sequencer.sv
// tb_rom_pwm_sequencer: directed runs with a queue of expected address events checked by a monitor
module tb_rom_pwm_sequencer;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, abort = 0;
  logic [15:0] step = 16'd1, tick_div = 16'd0;
  logic [15:0] pwm1, pwm2, pwm3;
  logic busy, wrap_pulse;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [15:0] addr; logic wrap; int gap;} exp_t;
  exp_t exp_q[$];
  logic [15:0] prev_addr = 0;
  logic prev_busy = 0;
  int gap_cnt = 0;
  rom_pwm_sequencer_if #(.ADDR_W(16), .DATA_W(16)) rom();
  rom_pwm_sequencer #(.ADDR_W(16), .DATA_W(16), .TABLE_LEN(16), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abort(abort),
    .step(step), .tick_div(tick_div), .rom(rom),
    .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3), .busy(busy), .wrap_pulse(wrap_pulse));
  function automatic logic [15:0] w1(input logic [15:0] a); return a ^ 16'hA5A5; endfunction
  function automatic logic [15:0] w2(input logic [15:0] a); return a * 16'd7 + 16'd1; endfunction
  function automatic logic [15:0] w3(input logic [15:0] a); return {a[7:0], ~a[7:0]}; endfunction
  assign rom.out1 = w1(rom.addr);
  assign rom.out2 = w2(rom.addr);
  assign rom.out3 = w3(rom.addr);
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic push(input logic [15:0] a, input logic w, input int g);
    exp_t e;
    e.addr = a; e.wrap = w; e.gap = g;
    exp_q.push_back(e);
  endtask
  task automatic push_seq(input int first, input int last, input int inc, input int g);
    for (int a = first; a <= last; a += inc) push(16'(a), 1'b0, g);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      gap_cnt++;
      check("pwm", {pwm1, pwm2, pwm3},
            prev_busy ? {w1(prev_addr), w2(prev_addr), w3(prev_addr)} : 48'h0);
      if (!prev_busy || rom.addr != prev_addr) begin
        if (exp_q.size() == 0) check("unexpected_addr", {48'h0, rom.addr}, 64'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("addr", {48'h0, rom.addr}, {48'h0, e.addr});
          check("wrap_pulse", {63'h0, wrap_pulse}, {63'h0, e.wrap});
          if (e.gap != 0) check("gap", 64'(gap_cnt), 64'(e.gap));
        end
        gap_cnt = 0;
      end
    end
    prev_busy = busy;
    prev_addr = rom.addr;
  end
  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic with_stop);
    step = s; tick_div = d; start = 1; stop = with_stop;
    @(negedge clk);
    start = 0; stop = 0;
  endtask
  task automatic pulse_stop();
    stop = 1;
    @(negedge clk);
    stop = 0;
  endtask
  task automatic wait_addr(input logic [15:0] a);
    int n = 0;
    while (rom.addr != a && n < 200) begin @(negedge clk); n++; end
    check("wait_addr", {48'h0, rom.addr}, {48'h0, a});
  endtask
  task automatic wait_wrap();
    int n = 0;
    do begin @(negedge clk); n++; end while (!wrap_pulse && n < 200);
    check("wait_wrap", {63'h0, wrap_pulse}, 64'h1);
  endtask
  task automatic check_idle(input string name);
    check({name, "_busy"}, {63'h0, busy}, 64'h0);
    check({name, "_en"}, {63'h0, rom.en}, 64'h0);
    check({name, "_addr"}, {48'h0, rom.addr}, 64'h0);
    check({name, "_pwm"}, {16'h0, pwm1, pwm2, pwm3}, 64'h0);
  endtask
  task automatic wait_fin(input logic [15:0] a);
    wait_wrap();
    check("fin_addr", {48'h0, rom.addr}, {48'h0, a});
    check("fin_busy", {63'h0, busy}, 64'h1);
    @(negedge clk);
    check_idle("fin_idle");
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", 64'(exp_q.size()), 64'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_wrap", {63'h0, wrap_pulse}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    // basic walk, second period stopped gracefully at addr 5
    push(16'd0, 1'b0, 0); push_seq(1, 15, 1, 1); push(16'd0, 1'b1, 1); push_seq(1, 15, 1, 1);
    do_start(16'd1, 16'd0, 1'b0);
    wait_wrap();
    wait_addr(16'd5);
    pulse_stop();
    wait_fin(16'd15);
    drain();
    // start and stop together: exactly one period
    push(16'd0, 1'b0, 0); push_seq(1, 15, 1, 1);
    do_start(16'd1, 16'd0, 1'b1);
    wait_fin(16'd15);
    drain();
    // step 3 with wrap arithmetic; step 0 applied mid-period takes effect (as 1) at the wrap
    push(16'd0, 1'b0, 0); push_seq(3, 15, 3, 1); push(16'd2, 1'b1, 1); push_seq(3, 15, 1, 1);
    do_start(16'd3, 16'd0, 1'b0);
    step = 16'd0;
    wait_wrap();
    pulse_stop();
    wait_fin(16'd15);
    drain();
    // rate 3 cycles per address; tick_div=0 at addr 4 only applies after the wrap
    push(16'd0, 1'b0, 0); push_seq(1, 15, 1, 3); push(16'd0, 1'b1, 3); push_seq(1, 15, 1, 1);
    do_start(16'd1, 16'd2, 1'b0);
    wait_addr(16'd4);
    tick_div = 16'd0;
    wait_wrap();
    pulse_stop();
    wait_fin(16'd15);
    drain();
    // abort at addr 7 with a concurrent start
    push(16'd0, 1'b0, 0); push_seq(1, 7, 1, 1);
    do_start(16'd1, 16'd0, 1'b0);
    wait_addr(16'd7);
    abort = 1; start = 1;
    @(negedge clk);
    abort = 0; start = 0;
    check_idle("abort");
    @(negedge clk);
    check("abort_start_ignored", {63'h0, busy}, 64'h0);
    drain();
    // restart samples new step/tick_div
    push(16'd0, 1'b0, 0); push_seq(5, 15, 5, 2); push(16'd4, 1'b1, 2); push_seq(9, 14, 5, 2);
    do_start(16'd5, 16'd1, 1'b0);
    wait_wrap();
    pulse_stop();
    wait_fin(16'd14);
    drain();
    // asynchronous reset mid-run at addr 9
    push(16'd0, 1'b0, 0); push_seq(1, 9, 1, 1);
    do_start(16'd1, 16'd0, 1'b0);
    wait_addr(16'd9);
    #2 rst_n = 0;
    #1 check_idle("async_reset");
    check("async_reset_wrap", {63'h0, wrap_pulse}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_idle("after_reset");
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
